// File: rtl/semaforo_pkg.sv
// semaforo_pkg: phase type, lamp patterns and legal phase succession shared by controller and monitor
package semaforo_pkg;
  typedef enum logic [1:0] {
    VERMELHO         = 2'b00,
    VERMELHO_AMARELO = 2'b01,
    VERDE            = 2'b10,
    AMARELO          = 2'b11
  } fase_t;
  localparam logic [2:0] LAMP_VERMELHO         = 3'b100;
  localparam logic [2:0] LAMP_VERMELHO_AMARELO = 3'b101;
  localparam logic [2:0] LAMP_VERDE            = 3'b010;
  localparam logic [2:0] LAMP_AMARELO          = 3'b001;
  function automatic fase_t next_fase(fase_t f);
    return fase_t'(f + 2'd1);
  endfunction
endpackage

// File: rtl/monitor_semaforo_decodificador_lampadas.sv
// decodificador_lampadas: maps the r/g/y lamp lines to a phase and flags illegal combinations
module decodificador_lampadas
  import semaforo_pkg::*;
(
  input  logic  r_i,
  input  logic  g_i,
  input  logic  y_i,
  output fase_t fase_o,
  output logic  legal_o
);
  logic [2:0] lamp;
  assign lamp = {r_i, g_i, y_i};
  assign legal_o = lamp inside {LAMP_VERMELHO, LAMP_VERMELHO_AMARELO, LAMP_VERDE, LAMP_AMARELO};
  assign fase_o = lamp == LAMP_VERMELHO_AMARELO ? VERMELHO_AMARELO :
                  lamp == LAMP_VERDE            ? VERDE :
                  lamp == LAMP_AMARELO          ? AMARELO : VERMELHO;
endmodule

// File: rtl/monitor_semaforo.sv
// monitor_semaforo: passive traffic-light lamp checker (combination, order, dwell, cycle count).
// Optional MONITOR_SEMAFORO_MIN_DWELL_EN adds erro_curto for phases left before MIN_DWELL cycles.
module monitor_semaforo
  import semaforo_pkg::*;
#(
  parameter int DWELL_W   = 8,
  parameter int MAX_DWELL = 200,
  parameter int CNT_W     = 16
`ifdef MONITOR_SEMAFORO_MIN_DWELL_EN
  , parameter int MIN_DWELL = 1
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               r,
  input  logic               g,
  input  logic               y,
  input  logic               limpa,
  output logic [1:0]         fase,
  output logic               fase_valida,
  output logic [DWELL_W-1:0] tempo_fase,
  output logic [CNT_W-1:0]   ciclos,
  output logic               erro_comb,
  output logic               erro_seq,
  output logic               timeout,
  output logic               falha
`ifdef MONITOR_SEMAFORO_MIN_DWELL_EN
  , output logic             erro_curto
`endif
);
  fase_t               dec, fase_q, fase_d;
  logic                legal, hold, succ;
  logic                synced_q, valida_q, comb_q, seq_q, to_q, falha_q;
  logic                synced_d, valida_d, comb_d, seq_d, to_d, falha_d, curto_d;
  logic [DWELL_W-1:0]  tempo_q, tempo_d;
  logic [CNT_W-1:0]    ciclos_q, ciclos_d;
  decodificador_lampadas u_dec (.r_i(r), .g_i(g), .y_i(y), .fase_o(dec), .legal_o(legal));
  assign hold = synced_q && legal && dec == fase_q;
  assign succ = synced_q && legal && dec == next_fase(fase_q);
  always_comb begin
    fase_d   = legal ? dec : fase_q;
    synced_d = legal;
    valida_d = legal;
    tempo_d  = !legal ? '0 : hold ? (&tempo_q ? tempo_q : tempo_q + 1'b1) : DWELL_W'(1);
    ciclos_d = ciclos_q + CNT_W'(succ && fase_q == AMARELO);
    comb_d   = !legal;
    seq_d    = synced_q && legal && !hold && !succ;
    // a saturated hold at MAX_DWELL must not re-fire; any fresh phase entry re-arms
    to_d     = legal && tempo_d == DWELL_W'(MAX_DWELL) && !(hold && tempo_q == DWELL_W'(MAX_DWELL));
`ifdef MONITOR_SEMAFORO_MIN_DWELL_EN
    curto_d  = synced_q && !hold && tempo_q < DWELL_W'(MIN_DWELL);
`else
    curto_d  = 1'b0;
`endif
    falha_d  = comb_d || seq_d || to_d || curto_d || (falha_q && !limpa);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fase_q   <= VERMELHO;
      synced_q <= 1'b0;
      valida_q <= 1'b0;
      tempo_q  <= '0;
      ciclos_q <= '0;
      comb_q   <= 1'b0;
      seq_q    <= 1'b0;
      to_q     <= 1'b0;
      falha_q  <= 1'b0;
    end else begin
      fase_q   <= fase_d;
      synced_q <= synced_d;
      valida_q <= valida_d;
      tempo_q  <= tempo_d;
      ciclos_q <= ciclos_d;
      comb_q   <= comb_d;
      seq_q    <= seq_d;
      to_q     <= to_d;
      falha_q  <= falha_d;
    end
`ifdef MONITOR_SEMAFORO_MIN_DWELL_EN
  logic curto_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) curto_q <= 1'b0;
    else curto_q <= curto_d;
  assign erro_curto = curto_q;
`endif
  assign fase        = fase_q;
  assign fase_valida = valida_q;
  assign tempo_fase  = tempo_q;
  assign ciclos      = ciclos_q;
  assign erro_comb   = comb_q;
  assign erro_seq    = seq_q;
  assign timeout     = to_q;
  assign falha       = falha_q;
endmodule

// File: tb/tb_monitor_semaforo.sv
// tb_monitor_semaforo: random and directed lamp traffic checked against a behavioural monitor model
module tb_monitor_semaforo;
  localparam int MAXD = 200;
  logic clk = 1'b0, rst = 1'b1, r = 1'b0, g = 1'b0, y = 1'b0, limpa = 1'b0;
  logic [1:0]  fase;
  logic [7:0]  tempo_fase;
  logic [15:0] ciclos;
  logic fase_valida, erro_comb, erro_seq, timeout, falha;
`ifdef MONITOR_SEMAFORO_MIN_DWELL_EN
  logic erro_curto;
`endif
  int checks = 0, errors = 0;
  int m_fase = 0, m_tempo = 0, m_ciclos = 0;
  bit m_sync = 0, m_valid = 0, m_ec = 0, m_es = 0, m_to = 0, m_falha = 0;
  bit en = 0;
  bit [2:0] lamp_of [4] = '{3'b100, 3'b101, 3'b010, 3'b001};
  bit [2:0] bad_of  [4] = '{3'b000, 3'b110, 3'b011, 3'b111};

  monitor_semaforo #(.DWELL_W(8), .MAX_DWELL(MAXD), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .r(r), .g(g), .y(y), .limpa(limpa),
    .fase(fase), .fase_valida(fase_valida), .tempo_fase(tempo_fase), .ciclos(ciclos),
    .erro_comb(erro_comb), .erro_seq(erro_seq), .timeout(timeout), .falha(falha)
`ifdef MONITOR_SEMAFORO_MIN_DWELL_EN
    , .erro_curto(erro_curto)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  function automatic int decode(bit [2:0] l);
    for (int i = 0; i < 4; i++) if (lamp_of[i] == l) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_fase = 0; m_tempo = 0; m_ciclos = 0;
    m_sync = 0; m_valid = 0; m_ec = 0; m_es = 0; m_to = 0; m_falha = 0;
  endfunction

  function automatic void model_step(bit [2:0] l, bit clr);
    int d = decode(l);
    m_ec = 0; m_es = 0; m_to = 0;
    if (d < 0) begin
      m_ec = 1; m_valid = 0; m_tempo = 0; m_sync = 0;
    end else begin
      m_valid = 1;
      if (m_sync && d == m_fase) begin
        if (m_tempo < 255) begin
          m_tempo++;
          if (m_tempo == MAXD) m_to = 1;
        end
      end else begin
        if (m_sync && d != (m_fase + 1) % 4) m_es = 1;
        if (m_sync && m_fase == 3 && d == 0) m_ciclos = (m_ciclos + 1) % 65536;
        m_fase = d; m_tempo = 1; m_sync = 1;
        if (MAXD == 1) m_to = 1;
      end
    end
    m_falha = m_ec | m_es | m_to | (m_falha & !clr);
  endfunction

  task automatic step(bit [2:0] l, bit clr);
    {r, g, y} = l;
    limpa = clr;
    @(posedge clk);
    model_step(l, clr);
    @(negedge clk);
  endtask

  always @(negedge clk) if (en) begin
    chk("fase", fase, m_fase);
    chk("fase_valida", fase_valida, m_valid);
    chk("tempo_fase", tempo_fase, m_tempo);
    chk("ciclos", ciclos, m_ciclos);
    chk("erro_comb", erro_comb, m_ec);
    chk("erro_seq", erro_seq, m_es);
    chk("timeout", timeout, m_to);
    chk("falha", falha, m_falha);
  end

  initial begin
    int cur, n_to, x, len;
    model_reset();
    #1 en = 1;
    @(negedge clk);
    chk("reset_fase", fase, 0);
    chk("reset_falha", falha, 0);
    rst = 1'b0;
    // clean cycle: 100,101,010,001,100
    for (int i = 0; i < 5; i++) step(lamp_of[i % 4], 0);
    chk("cycle_ciclos", ciclos, 1);
    chk("cycle_fase", fase, 0);
    chk("cycle_falha", falha, 0);
    // skip 00 -> 10
    step(3'b100, 0);
    step(3'b010, 0);
    chk("skip_erro_seq", erro_seq, 1);
    chk("skip_fase", fase, 2);
    chk("skip_falha", falha, 1);
    step(3'b010, 1);
    chk("limpa_falha", falha, 0);
    chk("limpa_seq", erro_seq, 0);
    // illegal then resync without sequence error
    step(3'b110, 0);
    chk("bad_comb", erro_comb, 1);
    chk("bad_valida", fase_valida, 0);
    chk("bad_fase", fase, 2);
    chk("bad_tempo", tempo_fase, 0);
    step(3'b010, 0);
    chk("resync_seq", erro_seq, 0);
    chk("resync_fase", fase, 2);
    chk("resync_valida", fase_valida, 1);
    // long hold for timeout
    n_to = 0;
    for (int i = 0; i < 210; i++) begin
      step(3'b100, 0);
      if (timeout) begin
        n_to++;
        chk("timeout_at", tempo_fase, MAXD);
      end
    end
    chk("timeout_count", n_to, 1);
    chk("hold_tempo", tempo_fase, 210);
    // limpa coinciding with a fault
    step(3'b010, 1);
    chk("limpa_vs_fault_seq", erro_seq, 1);
    chk("limpa_vs_fault_falha", falha, 1);
    // async reset mid-phase
    step(3'b010, 0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_fase", fase, 0);
    chk("arst_tempo", tempo_fase, 0);
    chk("arst_ciclos", ciclos, 0);
    chk("arst_falha", falha, 0);
    chk("arst_valida", fase_valida, 0);
    @(negedge clk);
    rst = 1'b0;
    step(3'b010, 0);
    chk("post_rst_seq", erro_seq, 0);
    chk("post_rst_fase", fase, 2);
    // randomized traffic
    cur = 0;
    for (int k = 0; k < 3000; k++) begin
      x = $urandom_range(0, 99);
      if (x < 60) step(lamp_of[cur], $urandom_range(0, 7) == 0);
      else if (x < 88) begin
        cur = (cur + 1) % 4;
        step(lamp_of[cur], $urandom_range(0, 7) == 0);
      end else if (x < 94) begin
        cur = $urandom_range(0, 3);
        step(lamp_of[cur], $urandom_range(0, 7) == 0);
      end else if (x < 99) step(bad_of[$urandom_range(0, 3)], $urandom_range(0, 7) == 0);
      else begin
        len = $urandom_range(195, 265);
        for (int i = 0; i < len; i++) step(lamp_of[cur], 0);
      end
    end
    en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
